tanh_share_sched: RTL and testbench
===================================

// Module: tanh_share_sched
// PURPOSE
// Round-robin scheduler sharing one fixed-latency tanh_FPsingle pipeline (LATENCY regs, enable-gated)
// among NREQ requesters. Accepts one FP32 operand per cycle over valid/ready, tracks requester IDs
// alongside the pipeline in a tag shift register, and collects results in an ordered result FIFO.
// Issue is credit-controlled, so the pipeline never stalls and never drops a result.
// PARAMETERS
// NREQ        4   number of requesters
// ID_W        2   requester ID width, = clog2(NREQ)
// LATENCY     4   pipeline depth: edges from pipe_in capture to valid pipe_out
// FIFO_DEPTH  8   result FIFO entries; also the total credit count
// PORTS
// clk        in   1          clock; all state updates on rising edge
// rst_n      in   1          asynchronous reset, active low
// req_valid  in   NREQ       per-requester operand valid
// req_data   in   NREQ*32    per-requester FP32 operand; requester i on [32*i+31:32*i]
// req_ready  out  NREQ       one-hot grant; transfer when req_valid[i] & req_ready[i]
// pipe_in    out  32         operand driven into the tanh pipeline
// pipe_en    out  1          enable for the tanh pipeline
// pipe_out   in   32         tanh pipeline result
// res_valid  out  1          result FIFO head valid
// res_ready  in   1          consumer accepts the head
// res_data   out  32         FP32 result at the head
// res_id     out  ID_W       requester ID of the head result
// busy       out  1          any tag in flight or FIFO not empty
// BEHAVIOUR
// Reset (async, rst_n=0): tags, FIFO pointers, counts and rr_ptr=0 cleared immediately.
//   Outputs during and after reset, until the next issue/push: req_ready=0, pipe_en=0, pipe_in=0,
//   res_valid=0, res_data=0, res_id=0, busy=0.
// Credit: used = inflight_cnt + fifo_cnt, both registered. Issue is allowed iff used < FIFO_DEPTH.
//   A pop frees its credit from the next cycle only.
// Arbiter (combinational on req_valid, rr_ptr, credit):
//   - Grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping mod NREQ.
//   - req_ready = one-hot grant, or 0 if no credit or nothing valid.
//   - After a transfer: rr_ptr <= granted+1 mod NREQ. Otherwise rr_ptr holds.
// Issue cycle t:
//   - pipe_in = req_data of the granted requester, else 0.
//   - pipe_en = issue | any tag valid. The pipeline is never stalled while occupied.
// Tag pipe: LATENCY stages of {valid, id}.
//   - Shifts on every cycle with pipe_en=1; stage0 <= {issue, grant_id}.
//   - Last stage valid in cycle t+LATENCY coincides with pipe_out valid.
//   - {id, pipe_out} is pushed into the FIFO at the end of that cycle.
// FIFO: first-word-fall-through.
//   - res_valid = !empty; res_data and res_id come from the head.
//   - Pop when res_valid & res_ready.
//   - Push and pop in the same cycle are both performed, including when full or empty.
//   - Pop when empty is ignored.
//   - Push when full cannot occur by credit; the bench asserts this.
// Latency: accept in cycle t -> res_valid in cycle t+LATENCY+1 when the FIFO is empty.
//   Throughput is 1 per cycle. Results leave in issue order.
// inflight_cnt: +1 on issue, -1 on push, both on the same cycle -> unchanged.
//   Range 0..LATENCY. fifo_cnt range 0..FIFO_DEPTH.
// Reset mid-operation: all in-flight and buffered results are discarded.
//   The pipeline's unreset data regs may hold garbage, but tag valids are 0, so garbage never reaches
//   the FIFO.
// busy = |tag valids | (fifo_cnt != 0).
// TESTING
// T1 req_valid=0010, req_data[1]=0x3F800000, res_ready=1:
//    req_ready=0010 in cycle 0; pipe_in=0x3F800000, pipe_en=1;
//    res_valid in cycle 5 with res_id=1 and res_data equal to pipe_out sampled in cycle 4.
// T2 req_valid=1111 held, res_ready=1:
//    grants 0,1,2,3,0,... one per cycle; res_id sequence 0,1,2,3,...; res_valid steady after cycle 5.
// T3 req_valid=1111 held, res_ready=0:
//    exactly 8 transfers, then req_ready=0000 and no FIFO overflow.
//    Raise res_ready: 8 results in order, and grants resume one cycle after the first pop.
// T4 rr_ptr=3, req_valid=0100 -> grant 2 and rr_ptr becomes 3.
//    Then req_valid=1001 -> grant 3, then 0.
// T5 rst_n=0 with 3 in flight and 2 buffered:
//    outputs go to 0 immediately.
//    After release with no requests: res_valid stays 0 for at least 10 cycles and busy=0.
// T6 integration with tanh pipeline, req 3 issues 0x41200000 (10.0) then 0xBF800000:
//    res_data 0x3F800000 then 0xBF42F7D6 (within 1 LSB of the table), both with res_id=3.

Source files
------------

// File: rtl/tanh_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : tanh_share_sched_if
// Brief    : Request, pipeline and result signals of the shared tanh scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface tanh_share_sched_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        pipe_in;
  logic               pipe_en;
  logic [31:0]        pipe_out;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_data;
  logic [ID_W-1:0]    res_id;
  logic               busy;

  // Environment side: requesters, tanh pipeline and result consumer
  modport master (
    output req_valid, req_data, pipe_out, res_ready,
    input  req_ready, pipe_in, pipe_en, res_valid, res_data, res_id, busy
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_data, pipe_out, res_ready,
    output req_ready, pipe_in, pipe_en, res_valid, res_data, res_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/tanh_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tanh_share_sched
// Brief    : Credit-controlled round-robin sharing of one tanh pipeline, with
//            requester tags tracked alongside and an in-order result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tanh_share_sched #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tanh_share_sched_if.slave  bus
);
  localparam int c_SUM_W = ID_W + 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]    r_tag_id [LATENCY];
  logic [c_CNT_W-1:0] r_inflight_cnt;
  logic [c_CNT_W-1:0] r_fifo_cnt;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [31:0]        r_mem_data [FIFO_DEPTH];
  logic [ID_W-1:0]    r_mem_id   [FIFO_DEPTH];

  logic               w_found;
  logic [ID_W-1:0]    w_gid;
  logic [c_SUM_W-1:0] w_cand;
  logic [c_SUM_W-1:0] w_nxt;
  logic [c_CNT_W:0]   w_used;
  logic               w_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_pipe_en;
  logic               w_res_valid;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Search from rr_ptr upward, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_cand  = '0;
    w_nxt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + c_SUM_W'(k);
      if (w_cand >= c_SUM_W'(NREQ)) w_cand = w_cand - c_SUM_W'(NREQ);
      if (!w_found && bus.req_valid[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_gid   = w_cand[ID_W-1:0];
      end
    end
    w_nxt = {1'b0, w_gid} + c_SUM_W'(1);
    if (w_nxt >= c_SUM_W'(NREQ)) w_nxt = w_nxt - c_SUM_W'(NREQ);
  end

  assign w_used   = {1'b0, r_inflight_cnt} + {1'b0, r_fifo_cnt};
  assign w_credit = (w_used < (c_CNT_W + 1)'(FIFO_DEPTH));
  // rst_n gates the grant so req_ready is held low while reset is asserted
  assign w_issue  = rst_n & w_credit & w_found;

  assign w_push      = r_tag_v[LATENCY-1];
  assign w_res_valid = (r_fifo_cnt != '0);
  assign w_pop       = w_res_valid & bus.res_ready;
  assign w_pipe_en   = w_issue | (|r_tag_v);

  assign bus.req_ready = w_issue ? (NREQ'(1) << w_gid) : '0;
  assign bus.pipe_in   = w_issue ? bus.req_data[{w_gid, 5'd0} +: 32] : '0;
  assign bus.pipe_en   = w_pipe_en;
  assign bus.res_valid = w_res_valid;
  assign bus.res_data  = w_res_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.res_id    = w_res_valid ? r_mem_id[r_rd_ptr]   : '0;
  assign bus.busy      = (|r_tag_v) | w_res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_tag_v        <= '0;
      r_inflight_cnt <= '0;
      r_fifo_cnt     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      for (int s = 0; s < LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      if (w_issue) r_rr_ptr <= w_nxt;

      // Tags advance in lockstep with the enable-gated pipeline data regs
      if (w_pipe_en) begin
        r_tag_v     <= {r_tag_v[LATENCY-2:0], w_issue};
        r_tag_id[0] <= w_gid;
        for (int s = 1; s < LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
      end

      case ({w_issue, w_push})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + c_CNT_W'(1);
        2'b01:   r_inflight_cnt <= r_inflight_cnt - c_CNT_W'(1);
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase

      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.pipe_out;
      r_mem_id[r_wr_ptr]   <= r_tag_id[LATENCY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tanh_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_share_sched
// Brief    : Self-checking bench for tanh_share_sched against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_share_sched;
  localparam int NREQ       = 4;
  localparam int ID_W       = 2;
  localparam int LATENCY    = 4;
  localparam int FIFO_DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tanh_share_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  tanh_share_sched #(
    .NREQ(NREQ), .ID_W(ID_W), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Small tanh table for known points; other operands get a fixed bit scramble
  function automatic logic [31:0] tanh_ref(input logic [31:0] x);
    case (x)
      32'h41200000: return 32'h3F800000;
      32'hBF800000: return 32'hBF42F7D6;
      32'h3F800000: return 32'h3F42F7D6;
      default:      return x ^ 32'h8000_5A5A;
    endcase
  endfunction

  // Enable-gated fixed-latency pipeline with unreset data regs
  logic [31:0] r_pipe [LATENCY];
  always @(posedge clk) begin
    if (bus.pipe_en) begin
      r_pipe[0] <= tanh_ref(bus.pipe_in);
      for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end
  assign bus.pipe_out = r_pipe[LATENCY-1];

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    int              avail;
  } res_t;

  res_t q[$];
  int   outstanding = 0;
  int   rr          = 0;
  int   cyc         = 0;
  int   n_checks    = 0;
  int   n_errors    = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_en;
    logic            exp_rv;
    logic [31:0]     exp_in;
    logic [31:0]     op;
    int              g;
    res_t            item;
    exp_rdy = '0;
    g       = -1;
    if (rst_n && outstanding < FIFO_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (rr + k) % NREQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    op     = (g >= 0) ? bus.req_data[32*g +: 32] : 32'h0;
    exp_in = op;
    exp_en = (g >= 0);
    foreach (q[i]) if (cyc >= q[i].avail - LATENCY && cyc < q[i].avail) exp_en = 1'b1;
    exp_rv = (q.size() > 0) && (q[0].avail <= cyc);

    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("pipe_en",   64'(bus.pipe_en),   64'(exp_en));
    check("pipe_in",   64'(bus.pipe_in),   64'(exp_in));
    check("res_valid", 64'(bus.res_valid), 64'(exp_rv));
    check("res_data",  64'(bus.res_data),  exp_rv ? 64'(q[0].data) : 64'h0);
    check("res_id",    64'(bus.res_id),    exp_rv ? 64'(q[0].id)   : 64'h0);
    check("busy",      64'(bus.busy),      64'(outstanding > 0));

    if (exp_rv && bus.res_ready) begin
      void'(q.pop_front());
      outstanding--;
    end
    if (g >= 0) begin
      item.id    = ID_W'(g);
      item.data  = tanh_ref(op);
      item.avail = cyc + LATENCY + 1;
      q.push_back(item);
      outstanding++;
      rr = (g + 1) % NREQ;
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] d, input logic rdy);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.res_ready = rdy;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [NREQ*32-1:0] rand_data();
    logic [NREQ*32-1:0] d;
    for (int i = 0; i < NREQ; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;

    // Reset with requests pending: everything must stay quiet
    repeat (3) step(4'b1111, rand_data(), 1'b1);
    rst_n = 1'b1;

    // Single request from requester 1
    step(4'b0010, {32'h0, 32'h0, 32'h3F800000, 32'h0}, 1'b1);
    repeat (8) step(4'b0000, rand_data(), 1'b1);

    // All requesting, consumer always ready
    repeat (20) step(4'b1111, rand_data(), 1'b1);
    repeat (10) step(4'b0000, rand_data(), 1'b1);

    // Consumer stalled: credit must cap issue at FIFO_DEPTH
    repeat (16) step(4'b1111, rand_data(), 1'b0);
    repeat (20) step(4'b1111, rand_data(), 1'b1);
    repeat (12) step(4'b0000, rand_data(), 1'b1);

    // Round-robin wrap
    step(4'b0100, rand_data(), 1'b1);
    step(4'b0100, rand_data(), 1'b1);
    step(4'b1001, rand_data(), 1'b1);
    step(4'b1001, rand_data(), 1'b1);
    repeat (8) step(4'b0000, rand_data(), 1'b1);

    // Reset with three in flight and two buffered
    repeat (5) step(4'b0001, rand_data(), 1'b0);
    step(4'b0000, rand_data(), 1'b0);
    check("pre_rst_valid", 64'(bus.res_valid), 64'h1);
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_pipe_en",   64'(bus.pipe_en),   64'h0);
    check("rst_pipe_in",   64'(bus.pipe_in),   64'h0);
    check("rst_res_valid", 64'(bus.res_valid), 64'h0);
    check("rst_res_data",  64'(bus.res_data),  64'h0);
    check("rst_res_id",    64'(bus.res_id),    64'h0);
    check("rst_busy",      64'(bus.busy),      64'h0);
    q.delete();
    outstanding = 0;
    rr          = 0;
    @(posedge clk);
    #1;
    cyc++;
    repeat (2) step(4'b1111, rand_data(), 1'b1);
    rst_n = 1'b1;
    repeat (12) step(4'b0000, rand_data(), 1'b1);

    // Requester 3 with known tanh points
    step(4'b1000, {32'h41200000, 96'h0}, 1'b1);
    step(4'b1000, {32'hBF800000, 96'h0}, 1'b1);
    repeat (8) step(4'b0000, rand_data(), 1'b1);

    // Random traffic: mostly-ready consumer, then mostly-stalled consumer
    repeat (200) step(NREQ'($urandom), rand_data(), $urandom_range(0, 3) != 0);
    repeat (200) step(NREQ'($urandom), rand_data(), $urandom_range(0, 3) == 0);
    repeat (30) step(4'b0000, rand_data(), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
